bridge_deadtime: RTL

- Gate-sequencing stage directly downstream of the converter control FSM.
- Takes the requested H-bridge switch pattern (top/bot leg masks) and drives the physical O_TOP/O_BOT pins.
- Guarantees a programmable all-off dead time between any two conducting patterns, a minimum on-time against chatter, and no shoot-through.
- An error kill overrides everything.

---
 rtl/bridge_deadtime_pkg.sv | 19 +
 rtl/bridge_deadtime_if.sv | 25 ++
 rtl/bridge_deadtime.sv | 99 +++++++++
 3 files changed

// File: rtl/bridge_deadtime_pkg.sv
// Shared types for the H-bridge dead-time stage: FSM state,
// leg mask type and the shoot-through legality check.
package bridge_pkg;

  typedef enum logic {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } bridge_state_t;

  typedef logic [3:0] leg_mask_t;

  function automatic logic is_legal(
    input leg_mask_t t,
    input leg_mask_t b
  );
    return (t & b) == '0;
  endfunction

endpackage

// File: rtl/bridge_deadtime_if.sv
// Gate request/drive bundle between the converter FSM and the pins.
// master: requests (top_req/bot_req/kill/clr_fault); slave: drives top/bot/busy/fault.
interface bridge_deadtime_if;
  import bridge_pkg::*;

  leg_mask_t top_req;
  leg_mask_t bot_req;
  logic      kill;
  logic      clr_fault;
  leg_mask_t top;
  leg_mask_t bot;
  logic      busy;
  logic      fault;

  modport master (
    output top_req, bot_req, kill, clr_fault,
    input  top, bot, busy, fault
  );

  modport slave (
    input  top_req, bot_req, kill, clr_fault,
    output top, bot, busy, fault
  );

endinterface

// File: rtl/bridge_deadtime.sv
// Dead-time / min-on gate sequencer with kill and sticky fault.
// Ports: clk, rstn (sync active-low), bus (slave: req in, gate drive out).
module bridge_deadtime
  import bridge_pkg::*;
#(
  parameter int FREQ     = 50000000,
  parameter int DEADTIME = FREQ / 500000,
  parameter int MIN_ON   = FREQ / 100000,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rstn,
  bridge_deadtime_if.slave   bus
);

  localparam logic [CNT_W-1:0] DT_LD = CNT_W'(DEADTIME);
  localparam logic [CNT_W-1:0] MO_LD = CNT_W'(MIN_ON);

  typedef struct packed {
    bridge_state_t    state;
    logic [CNT_W-1:0] timer;
    logic [7:0]       cur;
    logic [7:0]       out;
    logic             fault;
  } reg_t;

  localparam reg_t REG_RST = '{
    state: S_OFF,
    timer: DT_LD,
    cur:   '0,
    out:   '0,
    fault: 1'b0
  };

  reg_t r_q;
  reg_t r_d;

  logic             legal;
  logic [7:0]       ereq;
  logic [CNT_W-1:0] tmr_dec;

  always_comb begin
    legal   = is_legal(bus.top_req, bus.bot_req);
    ereq    = (bus.kill || !legal) ? 8'h00
                                   : {bus.top_req, bus.bot_req};
    tmr_dec = (r_q.timer == '0) ? '0 : r_q.timer - 1'b1;

    r_d       = r_q;
    r_d.fault = (r_q.fault && !bus.clr_fault) || !legal;

    if (bus.kill) begin
      // Hold dead time at full length until kill drops.
      r_d.state = S_OFF;
      r_d.timer = DT_LD;
      r_d.out   = '0;
    end else begin
      unique case (r_q.state)
        S_OFF: begin
          if (r_q.timer != '0) begin
            r_d.timer = tmr_dec;
          end else if (ereq != '0) begin
            r_d.state = S_ON;
            r_d.timer = MO_LD;
            r_d.cur   = ereq;
            r_d.out   = ereq;
          end
        end
        S_ON: begin
          r_d.timer = tmr_dec;
          // Zero request exits at once; a different pattern
          // waits for min-on to expire.
          if (ereq != r_q.cur &&
              (ereq == '0 || r_q.timer == '0)) begin
            r_d.state = S_OFF;
            r_d.timer = DT_LD;
            r_d.out   = '0;
          end
        end
        default: begin
          r_d = REG_RST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= REG_RST;
    end else begin
      r_q <= r_d;
    end
  end

  assign bus.top   = r_q.out[7:4];
  assign bus.bot   = r_q.out[3:0];
  assign bus.fault = r_q.fault;
  assign bus.busy  = (r_q.state == S_OFF) && (r_q.timer != '0);

endmodule
